call_stack_ctrl: RTL and testbench
==================================

Name: call_stack_ctrl

Overview:
- Write side of the return-address stack held in data memory.
- On a call, it pushes the return PC into data memory and moves the stack pointer down.
- On a return, it pops the stack: moves the pointer up, reads the slot, and presents the fetched address with a valid strobe.
- Sits between the control unit (stack_ctl, PC) and the data-memory port; stalls the core while a memory access is in flight.

Parameters:
- ADDR_W, 8, width of PC, data-memory address and data.
- STACK_TOP, 8'hFF, first free stack slot after reset; stack grows downward.
- STACK_DEPTH, 16, maximum number of stored return addresses.
- MEM_RD_LAT, 1, cycles from mem_re assertion to mem_rdata valid; range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stack_ctl  in  2  0=none, 1=call(push), 2=reserved (treated as none), 3=return(pop).
- pc_next  in  ADDR_W  return address to push on call.
- mem_addr  out  ADDR_W  data-memory address.
- mem_wdata  out  ADDR_W  data-memory write data.
- mem_we  out  1  data-memory write strobe, one cycle.
- mem_re  out  1  data-memory read strobe, one cycle.
- mem_rdata  in  ADDR_W  data-memory read data.
- ret_addr  out  ADDR_W  popped return address.
- ret_valid  out  1  one-cycle pulse; ret_addr valid.
- stall  out  1  core must hold PC and stack_ctl.
- sp  out  ADDR_W  current stack pointer, next free slot.
- depth  out  5  number of entries on the stack.
- overflow  out  1  sticky: call attempted with a full stack.
- underflow  out  1  sticky: return attempted with an empty stack.

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE, sp=STACK_TOP, depth=0.
  - mem_we, mem_re, ret_valid, stall, overflow, underflow = 0.
  - mem_addr, mem_wdata, ret_addr = 0.
  - rst overrides every state; an in-flight push or pop is abandoned and no further strobes are issued.
- All outputs are registered. stall = 1 in PUSH, POP_RD and POP_WAIT; 0 otherwise.
- stack_ctl is sampled only in IDLE and ignored in every other state.
- IDLE:
  - stack_ctl=1 with depth<STACK_DEPTH: latch pc_next and the current sp, go to PUSH.
  - stack_ctl=1 with depth==STACK_DEPTH: set overflow, stay IDLE, no write.
  - stack_ctl=3 with depth>0: go to POP_RD.
  - stack_ctl=3 with depth==0: set underflow, stay IDLE, no read, no ret_valid.
  - stack_ctl=0 or 2: stay IDLE.
- PUSH (1 cycle):
  - mem_we=1, mem_addr=latched sp, mem_wdata=latched pc_next.
  - sp<=sp-1, depth<=depth+1, then go to IDLE.
  - Call latency: the write is visible 1 cycle after the command cycle.
- POP_RD (1 cycle):
  - mem_re=1, mem_addr=sp+1 (mod 2^ADDR_W).
  - sp<=sp+1, depth<=depth-1, then go to POP_WAIT.
- POP_WAIT:
  - Counts MEM_RD_LAT cycles.
  - In the final count cycle, ret_addr<=mem_rdata, then go to POP_DONE.
- POP_DONE (1 cycle): ret_valid=1, stall=0, then go to IDLE.
- Return latency: ret_valid rises MEM_RD_LAT+2 cycles after the command cycle (3 cycles at default).
- ret_addr holds its value until the next pop completes.
- sp arithmetic is modulo 2^ADDR_W; wrap is never reached when STACK_TOP >= STACK_DEPTH-1, which the integrator guarantees.
- overflow and underflow clear only on rst; the blocked operation has no other effect.
- mem_we and mem_re are never high in the same cycle; neither strobe is high outside PUSH or POP_RD.
- Back-to-back commands: a command presented in the cycle the block returns to IDLE is accepted.
  - call→call spacing is 2 cycles.
  - return→next command spacing is MEM_RD_LAT+3 cycles.

Test Plan:
- Reset, then call with pc_next=8'h12 → next cycle mem_we=1, mem_addr=8'hFF, mem_wdata=8'h12; afterwards sp=8'hFE, depth=1, stall high exactly 1 cycle.
- Calls with 8'h12 then 8'h34, then return with the memory model returning stored data → mem_re=1 at mem_addr=8'hFE; ret_valid 3 cycles after the command with ret_addr=8'h34; sp=8'hFE, depth=1.
- Return with depth=0 → underflow=1, no mem_re, no ret_valid, sp stays 8'hFF.
- 16 calls then a 17th call → 16 writes to 8'hFF..8'hF0; 17th sets overflow with no write; depth=16, sp=8'hEF.
- MEM_RD_LAT=3, one call (8'hA5) then return → ret_valid 5 cycles after the command, ret_addr=8'hA5, stall high for 4 cycles.
- Return issued, rst asserted in the POP_WAIT cycle → next cycle all outputs at reset values, no ret_valid afterwards, sp=8'hFF, depth=0.

Source files
------------

// File: rtl/call_stack_ctrl_if.sv
// Data-memory port between the call-stack controller (master) and data memory (slave).
interface call_stack_ctrl_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_re,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/call_stack_ctrl.sv
// Return-address stack controller: pushes return PCs into data memory on call and
// pops them back on return, stalling the core while the memory access is in flight.
module call_stack_ctrl #(
    parameter int unsigned        ADDR_W      = 8,
    parameter logic [ADDR_W-1:0]  STACK_TOP   = 8'hFF,
    parameter int unsigned        STACK_DEPTH = 16,
    parameter int unsigned        MEM_RD_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          stack_ctl,
    input  logic [ADDR_W-1:0]   pc_next,
    call_stack_ctrl_if.master   mem,
    output logic [ADDR_W-1:0]   ret_addr,
    output logic                ret_valid,
    output logic                stall,
    output logic [ADDR_W-1:0]   sp,
    output logic [4:0]          depth,
    output logic                overflow,
    output logic                underflow
);

    localparam logic [1:0] CtlCall = 2'd1;
    localparam logic [1:0] CtlRet  = 2'd3;
    localparam logic [1:0] LatLast = 2'(MEM_RD_LAT - 1);
    localparam logic [4:0] DepthMax = 5'(STACK_DEPTH);

    typedef enum logic [2:0] {StIdle, StPush, StPopRd, StPopWait, StPopDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [4:0]        depth_q, depth_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
    logic              ret_valid_q, ret_valid_d;
    logic              stall_q, stall_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    // Output registers are loaded with the values of the state being entered.
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        depth_d     = depth_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        ret_addr_d  = ret_addr_q;
        ret_valid_d = 1'b0;
        stall_d     = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        unique case (state_q)
            StIdle: begin
                if (stack_ctl == CtlCall) begin
                    if (depth_q < DepthMax) begin
                        state_d     = StPush;
                        mem_we_d    = 1'b1;
                        stall_d     = 1'b1;
                        mem_addr_d  = sp_q;
                        mem_wdata_d = pc_next;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (stack_ctl == CtlRet) begin
                    if (depth_q != 5'd0) begin
                        state_d    = StPopRd;
                        mem_re_d   = 1'b1;
                        stall_d    = 1'b1;
                        mem_addr_d = sp_q + ADDR_W'(1);
                    end else begin
                        underflow_d = 1'b1;
                    end
                end
            end
            StPush: begin
                sp_d    = sp_q - ADDR_W'(1);
                depth_d = depth_q + 5'd1;
                state_d = StIdle;
            end
            StPopRd: begin
                sp_d    = sp_q + ADDR_W'(1);
                depth_d = depth_q - 5'd1;
                cnt_d   = LatLast;
                stall_d = 1'b1;
                state_d = StPopWait;
            end
            StPopWait: begin
                if (cnt_q == 2'd0) begin
                    ret_addr_d  = mem.mem_rdata;
                    ret_valid_d = 1'b1;
                    state_d     = StPopDone;
                end else begin
                    cnt_d   = cnt_q - 2'd1;
                    stall_d = 1'b1;
                end
            end
            StPopDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sp_q        <= STACK_TOP;
            depth_q     <= 5'd0;
            cnt_q       <= 2'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            ret_addr_q  <= '0;
            ret_valid_q <= 1'b0;
            stall_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            depth_q     <= depth_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            ret_addr_q  <= ret_addr_d;
            ret_valid_q <= ret_valid_d;
            stall_q     <= stall_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_re    = mem_re_q;
    assign ret_addr      = ret_addr_q;
    assign ret_valid     = ret_valid_q;
    assign stall         = stall_q;
    assign sp            = sp_q;
    assign depth         = depth_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Directed bench for call_stack_ctrl: one instance at read latency 1, one at latency 3,
// each backed by a simple data-memory model.
module tb_call_stack_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] ctl_a = 2'd0, ctl_b = 2'd0;
    logic [7:0] pc_a = 8'h00, pc_b = 8'h00;

    logic [7:0] ret_addr_a, ret_addr_b, sp_a, sp_b;
    logic       ret_valid_a, ret_valid_b, stall_a, stall_b;
    logic [4:0] depth_a, depth_b;
    logic       ovf_a, ovf_b, unf_a, unf_b;

    int errors = 0;
    int checks = 0;

    call_stack_ctrl_if #(.ADDR_W(8)) ia ();
    call_stack_ctrl_if #(.ADDR_W(8)) ib ();

    always #5 clk = ~clk;

    call_stack_ctrl #(.ADDR_W(8), .STACK_TOP(8'hFF), .STACK_DEPTH(16), .MEM_RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .stack_ctl(ctl_a), .pc_next(pc_a), .mem(ia),
        .ret_addr(ret_addr_a), .ret_valid(ret_valid_a), .stall(stall_a), .sp(sp_a),
        .depth(depth_a), .overflow(ovf_a), .underflow(unf_a)
    );

    call_stack_ctrl #(.ADDR_W(8), .STACK_TOP(8'hFF), .STACK_DEPTH(16), .MEM_RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .stack_ctl(ctl_b), .pc_next(pc_b), .mem(ib),
        .ret_addr(ret_addr_b), .ret_valid(ret_valid_b), .stall(stall_b), .sp(sp_b),
        .depth(depth_b), .overflow(ovf_b), .underflow(unf_b)
    );

    // Memory models: read data appears MEM_RD_LAT cycles after the read strobe.
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] rd_a, p0_b, p1_b, p2_b;
    int we_cnt_a = 0, re_cnt_a = 0, rv_cnt_a = 0, both_cnt = 0;

    always @(posedge clk) begin
        if (ia.mem_we) mem_a[ia.mem_addr] <= ia.mem_wdata;
        rd_a <= mem_a[ia.mem_addr];
        if (ib.mem_we) mem_b[ib.mem_addr] <= ib.mem_wdata;
        p0_b <= mem_b[ib.mem_addr];
        p1_b <= p0_b;
        p2_b <= p1_b;
        if (ia.mem_we) we_cnt_a <= we_cnt_a + 1;
        if (ia.mem_re) re_cnt_a <= re_cnt_a + 1;
        if (ret_valid_a) rv_cnt_a <= rv_cnt_a + 1;
        if ((ia.mem_we && ia.mem_re) || (ib.mem_we && ib.mem_re)) both_cnt <= both_cnt + 1;
    end

    assign ia.mem_rdata = rd_a;
    assign ib.mem_rdata = p2_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int we_snap, re_snap, rv_snap;

    initial begin
        tick();
        tick();
        rst = 1'b0;

        check("rst_sp", 32'(sp_a), 32'hFF);
        check("rst_depth", 32'(depth_a), 0);
        check("rst_stall", 32'(stall_a), 0);
        check("rst_we", 32'(ia.mem_we), 0);
        check("rst_re", 32'(ia.mem_re), 0);
        check("rst_rv", 32'(ret_valid_a), 0);
        check("rst_flags", {30'd0, ovf_a, unf_a}, 0);
        check("rst_addr", 32'(ia.mem_addr), 0);

        // Call 0x12
        ctl_a = 2'd1; pc_a = 8'h12;
        tick();
        ctl_a = 2'd0;
        check("push1_we", 32'(ia.mem_we), 1);
        check("push1_addr", 32'(ia.mem_addr), 32'hFF);
        check("push1_wdata", 32'(ia.mem_wdata), 32'h12);
        check("push1_stall", 32'(stall_a), 1);
        tick();
        check("push1_we_off", 32'(ia.mem_we), 0);
        check("push1_stall_off", 32'(stall_a), 0);
        check("push1_sp", 32'(sp_a), 32'hFE);
        check("push1_depth", 32'(depth_a), 1);

        // Call 0x34 back-to-back
        ctl_a = 2'd1; pc_a = 8'h34;
        tick();
        ctl_a = 2'd0;
        check("push2_addr", 32'(ia.mem_addr), 32'hFE);
        check("push2_wdata", 32'(ia.mem_wdata), 32'h34);
        tick();
        check("push2_sp", 32'(sp_a), 32'hFD);
        check("push2_depth", 32'(depth_a), 2);

        // Return: ret_valid lands 3 cycles after the command
        ctl_a = 2'd3;
        tick();
        ctl_a = 2'd0;
        check("pop1_re", 32'(ia.mem_re), 1);
        check("pop1_addr", 32'(ia.mem_addr), 32'hFE);
        check("pop1_stall_c1", 32'(stall_a), 1);
        check("pop1_rv_c1", 32'(ret_valid_a), 0);
        tick();
        check("pop1_re_c2", 32'(ia.mem_re), 0);
        check("pop1_stall_c2", 32'(stall_a), 1);
        check("pop1_rv_c2", 32'(ret_valid_a), 0);
        tick();
        check("pop1_rv_c3", 32'(ret_valid_a), 1);
        check("pop1_ret_addr", 32'(ret_addr_a), 32'h34);
        check("pop1_stall_c3", 32'(stall_a), 0);
        check("pop1_sp", 32'(sp_a), 32'hFE);
        check("pop1_depth", 32'(depth_a), 1);
        tick();
        check("pop1_rv_c4", 32'(ret_valid_a), 0);
        check("pop1_ret_hold", 32'(ret_addr_a), 32'h34);

        // Second return empties the stack
        ctl_a = 2'd3;
        tick();
        ctl_a = 2'd0;
        check("pop2_addr", 32'(ia.mem_addr), 32'hFF);
        tick();
        tick();
        check("pop2_rv", 32'(ret_valid_a), 1);
        check("pop2_ret_addr", 32'(ret_addr_a), 32'h12);
        check("pop2_depth", 32'(depth_a), 0);
        tick();

        // Return on empty stack
        re_snap = re_cnt_a; rv_snap = rv_cnt_a;
        ctl_a = 2'd3;
        tick();
        ctl_a = 2'd0;
        check("unf_flag", 32'(unf_a), 1);
        check("unf_stall", 32'(stall_a), 0);
        tick();
        tick();
        tick();
        check("unf_no_re", 32'(re_cnt_a - re_snap), 0);
        check("unf_no_rv", 32'(rv_cnt_a - rv_snap), 0);
        check("unf_sp", 32'(sp_a), 32'hFF);

        // Fill the stack, then overflow it
        for (int i = 0; i < 16; i++) begin
            ctl_a = 2'd1; pc_a = 8'h40 + 8'(i);
            tick();
            ctl_a = 2'd0;
            check("fill_addr", 32'(ia.mem_addr), 32'hFF - 32'(i));
            tick();
        end
        check("fill_depth", 32'(depth_a), 16);
        check("fill_mem_f0", 32'(mem_a[8'hF0]), 32'h4F);
        we_snap = we_cnt_a;
        ctl_a = 2'd1; pc_a = 8'hEE;
        tick();
        ctl_a = 2'd0;
        check("ovf_flag", 32'(ovf_a), 1);
        check("ovf_stall", 32'(stall_a), 0);
        tick();
        tick();
        check("ovf_no_we", 32'(we_cnt_a - we_snap), 0);
        check("ovf_depth", 32'(depth_a), 16);
        check("ovf_sp", 32'(sp_a), 32'hEF);
        check("unf_sticky", 32'(unf_a), 1);

        // Reset during POP_WAIT abandons the pop
        ctl_a = 2'd3;
        tick();
        ctl_a = 2'd0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rv_snap = rv_cnt_a;
        check("rstpop_sp", 32'(sp_a), 32'hFF);
        check("rstpop_depth", 32'(depth_a), 0);
        check("rstpop_stall", 32'(stall_a), 0);
        check("rstpop_rv", 32'(ret_valid_a), 0);
        check("rstpop_flags", {30'd0, ovf_a, unf_a}, 0);
        check("rstpop_ret_addr", 32'(ret_addr_a), 0);
        check("rstpop_addr", 32'(ia.mem_addr), 0);
        tick();
        tick();
        tick();
        check("rstpop_no_rv", 32'(rv_cnt_a - rv_snap), 0);

        // Read latency 3: stall 4 cycles, ret_valid 5 cycles after the command
        ctl_b = 2'd1; pc_b = 8'hA5;
        tick();
        ctl_b = 2'd0;
        tick();
        ctl_b = 2'd3;
        tick();
        ctl_b = 2'd0;
        check("lat3_re", 32'(ib.mem_re), 1);
        check("lat3_addr", 32'(ib.mem_addr), 32'hFF);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) tick();
            check("lat3_stall", 32'(stall_b), (k <= 4) ? 32'd1 : 32'd0);
            check("lat3_rv", 32'(ret_valid_b), (k == 5) ? 32'd1 : 32'd0);
        end
        check("lat3_ret_addr", 32'(ret_addr_b), 32'hA5);
        check("lat3_depth", 32'(depth_b), 0);
        tick();

        check("we_re_exclusive", 32'(both_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
